// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber step sequencer: FSM states, mask width and
// the step mask constants (MSB = step 0).
package kyber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MASK_W = 73;

    localparam logic [MASK_W-1:0] MASK_MSB  = {1'b1, 72'd0};

    // sel=0,k=2: four polynomials of six steps each
    localparam logic [MASK_W-1:0] PATT_S0K2 = {{4{6'b100000}}, 49'd0};
    localparam logic [MASK_W-1:0] ETA3_S0K2 = {{4{6'b110000}}, 49'd0};
    localparam logic [MASK_W-1:0] ETA3_S1K2 = {8'b1100_0011, 65'd0};

    // A single end marker at step (length - 1)
    localparam logic [MASK_W-1:0] ENDP_S0K2 = MASK_MSB >> 23;
    localparam logic [MASK_W-1:0] ENDP_S0K3 = MASK_MSB >> 41;
    localparam logic [MASK_W-1:0] ENDP_S0K4 = MASK_MSB >> 71;
    localparam logic [MASK_W-1:0] ENDP_S1K2 = MASK_MSB >> 22;
    localparam logic [MASK_W-1:0] ENDP_S1K3 = MASK_MSB >> 42;
    localparam logic [MASK_W-1:0] ENDP_DFLT = MASK_MSB >> 72;

endpackage

// File: rtl/kyber_mask_rom.sv
// Combinational {sel,k} to step-mask lookup feeding the sequencer shift registers.
module kyber_mask_rom
    import kyber_pkg::*;
(
    input  logic              i_sel,
    input  logic [2:0]        i_k,
    output logic [MASK_W-1:0] o_patt,
    output logic [MASK_W-1:0] o_eta3,
    output logic [MASK_W-1:0] o_endp
);

    always_comb begin
        o_patt = '0;
        o_eta3 = '0;
        o_endp = ENDP_DFLT;
        case ({i_sel, i_k})
            4'b0_010: begin
                o_patt = PATT_S0K2;
                o_eta3 = ETA3_S0K2;
                o_endp = ENDP_S0K2;
            end
            4'b0_011: o_endp = ENDP_S0K3;
            4'b0_100: o_endp = ENDP_S0K4;
            4'b1_010: begin
                o_eta3 = ETA3_S1K2;
                o_endp = ENDP_S1K2;
            end
            4'b1_011: o_endp = ENDP_S1K3;
            default:  o_endp = ENDP_DFLT;
        endcase
    end

endmodule

// File: rtl/kyber_step_sequencer.sv
// Kyber sampling step sequencer: IDLE/RUN/DONE FSM driving three mask shift registers.
// Optional abort input enabled by defining KYBER_SEQ_ABORT_EN.
module kyber_step_sequencer
    import kyber_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] k,
    input  logic       sel,
    input  logic       step_ready,
`ifdef KYBER_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       step_valid,
    output logic       new_poly,
    output logic       eta3_sel,
    output logic       last,
    output logic [6:0] step_idx,
    output logic       busy,
    output logic       done
);

    state_t            r_state;
    logic [MASK_W-1:0] r_patt;
    logic [MASK_W-1:0] r_eta3;
    logic [MASK_W-1:0] r_endp;
    logic [6:0]        r_step_idx;

    logic [MASK_W-1:0] w_patt;
    logic [MASK_W-1:0] w_eta3;
    logic [MASK_W-1:0] w_endp;
    logic              w_run;

    kyber_mask_rom u_mask_rom (
        .i_sel  (sel),
        .i_k    (k),
        .o_patt (w_patt),
        .o_eta3 (w_eta3),
        .o_endp (w_endp)
    );

    // Loading the masks on an accepted start is what captures {sel,k};
    // later input changes cannot reach the shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_patt     <= '0;
            r_eta3     <= '0;
            r_endp     <= '0;
            r_step_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_patt     <= w_patt;
                        r_eta3     <= w_eta3;
                        r_endp     <= w_endp;
                        r_step_idx <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef KYBER_SEQ_ABORT_EN
                    if (abort) begin
                        r_patt     <= '0;
                        r_eta3     <= '0;
                        r_endp     <= '0;
                        r_step_idx <= '0;
                        r_state    <= ST_IDLE;
                    end else
`endif
                    if (step_ready) begin
                        r_patt     <= r_patt << 1;
                        r_eta3     <= r_eta3 << 1;
                        r_endp     <= r_endp << 1;
                        r_step_idx <= r_step_idx + 7'd1;
                        if (r_endp[MASK_W-1]) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign step_valid = w_run;
    assign new_poly   = w_run & r_patt[MASK_W-1];
    assign eta3_sel   = w_run & r_eta3[MASK_W-1];
    assign last       = w_run & r_endp[MASK_W-1];
    assign step_idx   = r_step_idx;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_kyber_step_sequencer.sv
// Self-checking bench for kyber_step_sequencer against a step-rule reference model.
module tb_kyber_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] k = 3'd0;
  logic       sel = 1'b0;
  logic       step_ready = 1'b0;
`ifdef KYBER_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       step_valid;
  logic       new_poly;
  logic       eta3_sel;
  logic       last;
  logic [6:0] step_idx;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kyber_step_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k          (k),
    .sel        (sel),
    .step_ready (step_ready),
`ifdef KYBER_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .step_valid (step_valid),
    .new_poly   (new_poly),
    .eta3_sel   (eta3_sel),
    .last       (last),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done)
  );

  // Reference model: sequence rules stated as plain arithmetic
  function automatic int exp_len(input logic s, input logic [2:0] kk);
    if (!s) begin
      case (kk)
        3'd2: return 24;
        3'd3: return 42;
        3'd4: return 72;
        default: return 73;
      endcase
    end
    case (kk)
      3'd2: return 23;
      3'd3: return 43;
      default: return 73;
    endcase
  endfunction

  function automatic logic exp_new_poly(input logic s, input logic [2:0] kk, input int i);
    return (!s && kk == 3'd2 && (i % 6) == 0);
  endfunction

  function automatic logic exp_eta3(input logic s, input logic [2:0] kk, input int i);
    if (!s && kk == 3'd2) return ((i % 6) < 2);
    if (s && kk == 3'd2) return (i == 0 || i == 1 || i == 6 || i == 7);
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit chk_idx);
    check({tag, "_valid"}, 32'(step_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_new_poly"}, 32'(new_poly), 32'd0);
    check({tag, "_eta3"}, 32'(eta3_sel), 32'd0);
    check({tag, "_last"}, 32'(last), 32'd0);
    if (chk_idx) check({tag, "_idx"}, 32'(step_idx), 32'd0);
  endtask

  // cut_kind: 0 none, 1 reset at cut_at, 2 abort at cut_at
  task automatic run_seq(input logic s, input logic [2:0] kk, input bit bp,
                         input int cut_at, input int cut_kind);
    int len;
    int idx;
    int cyc;
    len = exp_len(s, kk);
    idx = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    sel = s;
    k = kk;
    @(negedge clk);
    start = 1'b0;
    sel = 1'($urandom_range(0, 1));
    k = 3'($urandom_range(0, 7));
    while (idx < len && cyc < 400) begin
      check("run_valid", 32'(step_valid), 32'd1);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_idx", 32'(step_idx), 32'(idx));
      check("run_new_poly", 32'(new_poly), 32'(exp_new_poly(s, kk, idx)));
      check("run_eta3", 32'(eta3_sel), 32'(exp_eta3(s, kk, idx)));
      check("run_last", 32'(last), 32'(idx == len - 1));
      if (cut_kind != 0 && idx == cut_at) begin
        step_ready = 1'b1;
        if (cut_kind == 1) rst_n = 1'b0;
`ifdef KYBER_SEQ_ABORT_EN
        else abort = 1'b1;
`endif
        @(negedge clk);
        check_idle("cut", 1'b1);
        rst_n = 1'b1;
`ifdef KYBER_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        check("cut_no_done", 32'(done), 32'd0);
        check("cut_busy", 32'(busy), 32'd0);
        return;
      end
      step_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (step_ready) idx++;
    end
    start = 1'b1;
    check("handshakes", 32'(idx), 32'(len));
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(step_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_last", 32'(last), 32'd0);
    check("done_new_poly", 32'(new_poly), 32'd0);
    check("done_eta3", 32'(eta3_sel), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_idle("post_done", 1'b0);
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b1);
    rst_n = 1'b1;

    run_seq(1'b0, 3'd2, 1'b0, -1, 0);
    run_seq(1'b1, 3'd3, 1'b0, -1, 0);
    run_seq(1'b0, 3'd4, 1'b0, -1, 0);
    run_seq(1'b0, 3'd5, 1'b0, -1, 0);
    run_seq(1'b1, 3'd2, 1'b1, -1, 0);
    run_seq(1'b0, 3'd3, 1'b0, 10, 1);
    run_seq(1'b0, 3'd2, 1'b0, -1, 0);
`ifdef KYBER_SEQ_ABORT_EN
    run_seq(1'b1, 3'd3, 1'b0, 5, 2);
    run_seq(1'b1, 3'd2, 1'b0, -1, 0);
`endif
    for (int r = 0; r < 4; r++) begin
      run_seq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
